multiport_regfile: RTL and testbench
====================================

// Module: multiport_regfile
// PURPOSE
//  Parametrised multi-port register file for the multicore pipeline (ID-stage operand read, WB-stage write).
//  Supports NUM_RD read ports and NUM_WR write ports, with registered reads and an optional hardwired zero register.
//  A clear sequencer zeroes the array one entry per cycle after reset or on request.
//  Busy is asserted while the clear runs, so the hazard unit stalls ID.
// PARAMETERS
//  WIDTH     32  data bits per register
//  DEPTH     32  number of registers (power of 2, >=2)
//  AW        5   address bits, = $clog2(DEPTH)
//  NUM_RD    2   read ports
//  NUM_WR    2   write ports
//  ZERO_REG  1   1: entry 0 always reads 0 and ignores writes; 0: entry 0 is an ordinary register
// PORTS
//  Clk      in   1              clock; all state updates on posedge
//  Rst_n    in   1              synchronous active-low reset
//  Clear    in   1              request full-array clear (single-cycle pulse or level)
//  Busy     out  1              clear sequence in progress
//  RdAddr   in   NUM_RD*AW      read addresses; port i = [i*AW +: AW]
//  RdData   out  NUM_RD*WIDTH   registered read data; port i = [i*WIDTH +: WIDTH]
//  WrEn     in   NUM_WR         per-port write enable
//  WrAddr   in   NUM_WR*AW      write addresses
//  WrData   in   NUM_WR*WIDTH   write data
// BEHAVIOUR
//  - Reset: if Rst_n=0 at posedge, then state=CLEAR, ptr=0, Busy=1, and all RdData=0. Array contents are not touched that cycle.
//  - FSM states IDLE and CLEAR:
//    CLEAR: each cycle writes 0 to entry ptr, then ptr+1.
//           At ptr==DEPTH-1, go to IDLE; Busy falls on that same edge.
//           Busy is high for exactly DEPTH cycles after reset release.
//    IDLE:  Clear=1 at posedge -> CLEAR with ptr=0 and Busy=1 from the next cycle.
//  - Clear asserted while in CLEAR is ignored; the sequence does not restart.
//  - Reset mid-clear: ptr returns to 0 and the full DEPTH-cycle sequence repeats.
//  - While Busy=1: all WrEn are ignored, and every RdData updates to 0.
//  - Writes (IDLE only):
//    - WrEn[j] writes WrData[j] to WrAddr[j] at posedge.
//    - Two ports writing the same address in the same cycle: the highest-index port wins.
//    - With ZERO_REG=1, writes to address 0 are dropped.
//  - Reads: latency 1. RdData[i] at posedge = array[RdAddr[i]] sampled at that edge, before that edge's writes (see CONFIGURATION).
//  - With ZERO_REG=1, RdAddr=0 always returns 0.
//  - Read ports are independent; any number may read the same address.
// CONFIGURATION
//  - Macro REGFILE_WR_BYPASS_EN:
//    - Defined: a read whose RdAddr matches an enabled same-cycle WrAddr returns the new WrData.
//      Highest-index matching write port wins. Address 0 is still forced to 0 when ZERO_REG=1.
//      This gives WB->ID forwarding with no stall.
//    - Undefined: a same-cycle read returns the pre-write value; the new value is visible one cycle later.
//  - The bypass never applies while Busy=1.
// TESTING
//  1. Rst_n=0 for 1 cycle, then 1 -> Busy=1 for 32 cycles then 0; every read returns 0; WrEn during Busy has no effect.
//  2. Write reg5=0xDEADBEEF on port0; read rs=5 next cycle -> RdData0=0xDEADBEEF one cycle later.
//  3. Port0 and port1 both write reg7 (0x11111111 / 0x22222222) -> reg7 reads 0x22222222.
//  4. With ZERO_REG=1, write reg0=0xFFFFFFFF -> reads of reg0 return 0.
//     With ZERO_REG=0 -> reads return 0xFFFFFFFF.
//  5. Same-cycle write reg9=0xA5A5A5A5 and read reg9 (old value 0x0):
//     - REGFILE_WR_BYPASS_EN defined -> 0xA5A5A5A5.
//     - Undefined -> 0x0, then 0xA5A5A5A5 the following cycle.
//  6. Clear pulse in IDLE -> 32 Busy cycles, regs zeroed.
//     A second Clear at cycle 10 -> no restart.
//     Rst_n=0 at cycle 20 -> a new 32-cycle sequence.

Source files
------------

// File: rtl/multiport_regfile_if.sv
// ============================================================================
// Module  : multiport_regfile_if
// Brief   : Read/write/clear bus of the multi-port register file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface multiport_regfile_if #(
  parameter int WIDTH  = 32,
  parameter int AW     = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) ();
  logic                     Clear;
  logic                     Busy;
  logic [NUM_RD*AW-1:0]     RdAddr;
  logic [NUM_RD*WIDTH-1:0]  RdData;
  logic [NUM_WR-1:0]        WrEn;
  logic [NUM_WR*AW-1:0]     WrAddr;
  logic [NUM_WR*WIDTH-1:0]  WrData;

  modport master (
    output Clear, RdAddr, WrEn, WrAddr, WrData,
    input  Busy, RdData
  );

  modport slave (
    input  Clear, RdAddr, WrEn, WrAddr, WrData,
    output Busy, RdData
  );
endinterface

`default_nettype wire

// File: rtl/multiport_regfile.sv
// ============================================================================
// Module  : multiport_regfile
// Brief   : NUM_RD/NUM_WR register file, registered reads, sequenced clear.
//           Optional same-cycle write->read bypass: REGFILE_WR_BYPASS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multiport_regfile #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  multiport_regfile_if.slave   bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_ptr;
  logic [AW-1:0]    w_ptr_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_busy;

  assign w_busy   = (r_state == S_CLEAR);
  assign bus.Busy = w_busy;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (bus.Clear) begin
          w_state_nxt = S_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      S_CLEAR: begin
        w_ptr_nxt = r_ptr + 1'b1;
        if (r_ptr == AW'(DEPTH - 1)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Storage is left untouched on the reset edge; the clear sequence zeroes it.
  // Ascending port loop: the last assignment (highest port) wins a collision.
  always_ff @(posedge Clk) begin
    if (Rst_n) begin
      if (w_busy) begin
        r_mem[r_ptr] <= '0;
      end else begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (bus.WrEn[j] && !(ZERO_REG != 0 && bus.WrAddr[j*AW +: AW] == '0)) begin
            r_mem[bus.WrAddr[j*AW +: AW]] <= bus.WrData[j*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0]    w_addr;
      logic [WIDTH-1:0] w_val;
      logic [WIDTH-1:0] r_rd;

      assign w_addr = bus.RdAddr[gi*AW +: AW];

      always_comb begin
        w_val = r_mem[w_addr];
`ifdef REGFILE_WR_BYPASS_EN
        for (int j = 0; j < NUM_WR; j++) begin
          if (bus.WrEn[j] && bus.WrAddr[j*AW +: AW] == w_addr) begin
            w_val = bus.WrData[j*WIDTH +: WIDTH];
          end
        end
`endif
        if (ZERO_REG != 0 && w_addr == '0) begin
          w_val = '0;
        end
      end

      always_ff @(posedge Clk) begin
        if (!Rst_n || w_busy) begin
          r_rd <= '0;
        end else begin
          r_rd <= w_val;
        end
      end

      assign bus.RdData[gi*WIDTH +: WIDTH] = r_rd;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_multiport_regfile.sv
// ============================================================================
// Module  : tb_multiport_regfile
// Brief   : Directed + randomized self-checking bench with behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiport_regfile;
  localparam int W  = 32;
  localparam int D  = 32;
  localparam int A  = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int ZR = 1;
`ifdef REGFILE_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multiport_regfile_if #(.WIDTH(W), .AW(A), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  multiport_regfile #(
    .WIDTH(W), .DEPTH(D), .AW(A), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(ZR)
  ) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: contents, pending clear cycles, expected registered reads.
  logic [W-1:0] m_mem [D];
  logic [W-1:0] m_rd  [NR];
  int           m_rem = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] nrd [NR];
    int a;
    for (int i = 0; i < NR; i++) nrd[i] = '0;
    if (!rst_n) begin
      m_rem = D;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) for (int k = 0; k < D; k++) m_mem[k] = '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        a = int'(bus.RdAddr[i*A +: A]);
        nrd[i] = m_mem[a];
        if (BYP)
          for (int j = 0; j < NW; j++)
            if (bus.WrEn[j] && int'(bus.WrAddr[j*A +: A]) == a) nrd[i] = bus.WrData[j*W +: W];
        if (ZR == 1 && a == 0) nrd[i] = '0;
      end
      for (int j = 0; j < NW; j++) begin
        a = int'(bus.WrAddr[j*A +: A]);
        if (bus.WrEn[j] && !(ZR == 1 && a == 0)) m_mem[a] = bus.WrData[j*W +: W];
      end
      if (bus.Clear) m_rem = D;
    end
    for (int i = 0; i < NR; i++) m_rd[i] = nrd[i];
  endtask

  task automatic compare();
    chk("busy", W'(bus.Busy), W'(m_rem > 0));
    for (int i = 0; i < NR; i++)
      chk($sformatf("rddata%0d", i), bus.RdData[i*W +: W], m_rd[i]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle();
    bus.Clear  = 1'b0;
    bus.WrEn   = '0;
    bus.WrAddr = '0;
    bus.WrData = '0;
    bus.RdAddr = '0;
  endtask

  task automatic set_wr(input int p, input int ad, input logic [W-1:0] dt);
    bus.WrEn[p]          = 1'b1;
    bus.WrAddr[p*A +: A] = A'(ad);
    bus.WrData[p*W +: W] = dt;
  endtask

  task automatic set_rd(input int p, input int ad);
    bus.RdAddr[p*A +: A] = A'(ad);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.Busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
  endtask

  int n;

  initial begin
    idle();
    rst_n = 1'b0;
    step();
    chk("reset_busy", W'(bus.Busy), 32'd1);
    chk("reset_rd0", bus.RdData[0 +: W], 32'h0);
    chk("reset_rd1", bus.RdData[W +: W], 32'h0);

    // Writes attempted throughout the post-reset clear must be dropped.
    rst_n = 1'b1;
    set_wr(0, 5, 32'h12345678);
    set_wr(1, 6, 32'h87654321);
    set_rd(0, 5);
    set_rd(1, 6);
    count_busy(n);
    chk("busy_len_reset", W'(n), 32'd32);
    idle();
    set_rd(0, 5);
    set_rd(1, 6);
    step();
    chk("busy_write_ignored5", bus.RdData[0 +: W], 32'h0);
    chk("busy_write_ignored6", bus.RdData[W +: W], 32'h0);

    idle();
    set_wr(0, 5, 32'hDEADBEEF);
    step();
    idle();
    set_rd(0, 5);
    step();
    chk("reg5", bus.RdData[0 +: W], 32'hDEADBEEF);

    idle();
    set_wr(0, 7, 32'h11111111);
    set_wr(1, 7, 32'h22222222);
    step();
    idle();
    set_rd(0, 7);
    set_rd(1, 7);
    step();
    chk("reg7_p0", bus.RdData[0 +: W], 32'h22222222);
    chk("reg7_p1", bus.RdData[W +: W], 32'h22222222);

    idle();
    set_wr(1, 0, 32'hFFFFFFFF);
    step();
    idle();
    set_rd(1, 0);
    step();
    chk("reg0", bus.RdData[W +: W], (ZR == 1) ? 32'h0 : 32'hFFFFFFFF);

    idle();
    set_wr(0, 9, 32'hA5A5A5A5);
    set_rd(0, 9);
    step();
    chk("reg9_same_cycle", bus.RdData[0 +: W], BYP ? 32'hA5A5A5A5 : 32'h0);
    idle();
    set_rd(0, 9);
    step();
    chk("reg9_next_cycle", bus.RdData[0 +: W], 32'hA5A5A5A5);

    // Clear pulse, then a second Clear at busy cycle 10 must not extend it.
    idle();
    bus.Clear = 1'b1;
    step();
    bus.Clear = 1'b0;
    n = 0;
    while (bus.Busy === 1'b1 && n < 100) begin
      bus.Clear = (n == 9);
      n++;
      step();
    end
    bus.Clear = 1'b0;
    chk("busy_len_clear", W'(n), 32'd32);
    set_rd(0, 5);
    set_rd(1, 7);
    step();
    chk("cleared_reg5", bus.RdData[0 +: W], 32'h0);
    chk("cleared_reg7", bus.RdData[W +: W], 32'h0);

    // Reset part-way through a clear restarts the full sequence.
    idle();
    set_wr(0, 3, 32'hCAFEF00D);
    step();
    idle();
    bus.Clear = 1'b1;
    step();
    bus.Clear = 1'b0;
    for (int k = 0; k < 19; k++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    count_busy(n);
    chk("busy_len_midreset", W'(n), 32'd32);
    set_rd(0, 3);
    step();
    chk("midreset_reg3", bus.RdData[0 +: W], 32'h0);

    // Randomized traffic; collisions favoured by a narrow address range.
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 599) != 0);
      bus.Clear = ($urandom_range(0, 249) == 0);
      for (int j = 0; j < NW; j++) begin
        bus.WrEn[j]          = $urandom_range(0, 1) == 1;
        bus.WrAddr[j*A +: A] = A'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, D-1));
        bus.WrData[j*W +: W] = $urandom;
      end
      for (int i = 0; i < NR; i++)
        bus.RdAddr[i*A +: A] = A'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, D-1));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
